// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data has fixed priority.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   d_req,
   input  owner_t last_served,
   output logic   grant,
   output owner_t win
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      grant = if_req | d_req;
      win   = OWN_D;
      if (if_req && d_req) begin
         // On a tie, favour whichever port was not served last.
         win = (last_served == OWN_D) ? OWN_IF : OWN_D;
      end else if (if_req) begin
         win = OWN_IF;
      end
   end
`else
   logic unused_last_served;
   assign unused_last_served = last_served;

   always_comb begin
      grant = if_req | d_req;
      win   = OWN_D;
      if (if_req && !d_req) begin
         win = OWN_IF;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store requests onto one memory port with a fixed read latency.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-over-fetch priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IF_REQ,
   input  logic [31:0] IF_ADDR,
   output logic        IF_ACK,
   output logic [31:0] IF_RDATA,
   input  logic        D_REQ,
   input  logic        D_WE,
   input  logic [31:0] D_ADDR,
   input  logic [31:0] D_WDATA,
   output logic        D_ACK,
   output logic [31:0] D_RDATA,
   output logic [31:0] MEM_ADDR,
   output logic        MEM_WR,
   output logic [31:0] MEM_WDATA,
   input  logic [31:0] MEM_RDATA,
   output logic        BUSY,
   output logic        OWNER
);

   localparam int CW = $clog2(MEM_LAT + 1);

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..4");
   end

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;
   logic          we_q, we_d;
   owner_t        owner_q, owner_d;

   logic          grant;
   owner_t        win;
   owner_t        last_served;

   mem_arb_pick u_pick (
      .if_req      (IF_REQ),
      .d_req       (D_REQ),
      .last_served (last_served),
      .grant       (grant),
      .win         (win)
   );

`ifdef MEM_ARB_RR_EN
   owner_t last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && grant) begin
         last_d = win;
      end
   end

   // Resets to data so that the first tie after reset goes to fetch.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         last_q <= OWN_D;
      end else begin
         last_q <= last_d;
      end
   end

   assign last_served = last_q;
`else
   assign last_served = OWN_D;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      we_d        = we_q;
      owner_d     = owner_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               owner_d = win;
               if (win == OWN_D) begin
                  mem_addr_d  = D_ADDR;
                  mem_wdata_d = D_WDATA;
                  we_d        = D_WE;
                  cnt_d       = D_WE ? CW'(1) : CW'(MEM_LAT);
               end else begin
                  mem_addr_d = IF_ADDR;
                  we_d       = 1'b0;
                  cnt_d      = CW'(MEM_LAT);
               end
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // Compare with <= so the counter can never wrap below zero.
            if (cnt_q <= CW'(1)) begin
               state_d = RESP;
               if (!we_q) begin
                  if (owner_q == OWN_D) begin
                     d_rdata_d = MEM_RDATA;
                  end else begin
                     if_rdata_d = MEM_RDATA;
                  end
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         we_q        <= 1'b0;
         owner_q     <= OWN_IF;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         we_q        <= we_d;
         owner_q     <= owner_d;
      end
   end

   // Strobe is decoded from state so it drops the moment RESET is asserted.
   assign MEM_WR    = (state_q == ACCESS) && we_q;
   assign IF_ACK    = (state_q == RESP) && (owner_q == OWN_IF);
   assign D_ACK     = (state_q == RESP) && (owner_q == OWN_D);
   assign BUSY      = (state_q != IDLE);
   assign OWNER     = owner_q;
   assign MEM_ADDR  = mem_addr_q;
   assign MEM_WDATA = mem_wdata_q;
   assign IF_RDATA  = if_rdata_q;
   assign D_RDATA   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and access sequencer sitting between the multicycle control unit's fetch path, its load/store path, and the shared 32-bit memory. It serialises instruction-fetch and data requests onto the one memory port. It holds address, write-enable and write-data stable for the memory's read latency, captures read data, and returns a one-cycle acknowledge to the requester that was served.

## Interface
- MEM_LAT, 1, memory read latency in cycles (legal 1..4; anything else fails elaboration)
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- IF_REQ  in  1  fetch request, held until IF_ACK
- IF_ADDR  in  32  fetch byte address, stable while IF_REQ
- IF_ACK  out  1  one-cycle completion pulse for fetch
- IF_RDATA  out  32  fetched word, registered, held until next IF_ACK
- D_REQ  in  1  data request, held until D_ACK
- D_WE  in  1  1 = store, 0 = load, stable while D_REQ
- D_ADDR  in  32  data byte address
- D_WDATA  in  32  store data
- D_ACK  out  1  one-cycle completion pulse for data
- D_RDATA  out  32  loaded word, registered, held until next D_ACK
- MEM_ADDR  out  32  memory address (registered)
- MEM_WR  out  1  memory write strobe
- MEM_WDATA  out  32  memory write data (registered)
- MEM_RDATA  in  32  memory read data
- BUSY  out  1  high whenever state is not IDLE
- OWNER  out  1  port currently or last served: 0 = fetch, 1 = data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any REQ is high, pick a winner.
  - Latch the winner's address, WE (0 for fetch) and WDATA into the MEM_* registers, and latch OWNER.
  - Load the counter with MEM_LAT for reads or 1 for writes, then go to ACCESS.
  - With no request, stay in IDLE. MEM_* keep their last values and MEM_WR = 0.
- ACCESS:
  - MEM_WR = latched WE; it is high in exactly one cycle per store.
  - The counter decrements each cycle. When it reaches 1, go to RESP.
  - On a read, the same edge loads MEM_RDATA into the winner's RDATA register.
- RESP:
  - Winner's ACK = 1 for this cycle only, then go to IDLE.
  - Requests are not sampled in RESP. A REQ still high in the following IDLE cycle is a new transaction.
- Arbitration, default build: D_REQ beats IF_REQ.
- REQ dropped mid-transaction: ignored. The access completes and ACK still pulses.
- Input changes mid-transaction have no effect, because address and data are latched in IDLE.
- The counter is $clog2(MEM_LAT+1) bits wide and never underflows.

## Timing
- Reset values:
  - State IDLE, all ACKs 0, MEM_WR 0.
  - MEM_ADDR, MEM_WDATA, IF_RDATA, D_RDATA, OWNER all 0.
  - Round-robin last-served register = data.
- RESET asserted mid-transaction: drops to IDLE immediately. MEM_WR falls asynchronously, no ACK is issued and the transaction is lost.
- Read latency: REQ sampled at edge 0 → ACCESS for MEM_LAT cycles → ACK in cycle MEM_LAT+1.
- Store latency: ACK in cycle 2 after the sampling edge.
- Back-to-back on one port: one IDLE cycle between transactions, so throughput is one read per MEM_LAT+2 cycles.
- Both REQs high in the same IDLE cycle: only one is served. The loser stays pending and is served after the following RESP.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant goes to the port not served last.
  - The last-served register resets to data, so the first tie goes to fetch.
  - The register updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, data over fetch. No last-served register exists.

## Structure
- Package mem_arb_pkg holds:
  - state_t enum (IDLE, ACCESS, RESP).
  - owner_t enum (OWN_IF = 0, OWN_D = 1).
  - The MEM_LAT legal-range constants.
- Sub-module mem_arb_pick: combinational winner selection from IF_REQ, D_REQ and last-served, with the MEM_ARB_RR_EN switch contained inside it.
- FSM, counter and data registers stay in the top module.

## Test plan
- MEM_LAT=1, fetch IF_ADDR=0x10, memory returns 0x00A00093 → IF_ACK in cycle 2 after sampling, IF_RDATA=0x00A00093, OWNER=0.
- Store D_ADDR=0x40, D_WDATA=0xDEADBEEF → MEM_WR high for exactly one cycle with MEM_ADDR=0x40, D_ACK in cycle 2; a following load from 0x40 gives D_RDATA=0xDEADBEEF.
- IF_REQ and D_REQ raised together twice:
  - Default build: data served first both times.
  - MEM_ARB_RR_EN: fetch first, then data on the next tie.
- MEM_LAT=3 read → MEM_ADDR stable for 3 ACCESS cycles, ACK in cycle 4, no other port's ACK pulses.
- RESET pulsed during the ACCESS of a store → MEM_WR 0 immediately, BUSY 0, no ACK, all outputs at reset values.
- D_REQ dropped after sampling → transaction completes and D_ACK still pulses once.
